// File: rtl/mux32_bist_pkg.sv
// Shared types and sizing helpers for the mux BIST controller.
package mux32_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_CHECK,
    ST_DONE
  } state_e;

  // Solid patterns occupy indices 0..3; walking-one pairs start at 4.
  localparam int PAT_ZERO_LO   = 0;
  localparam int PAT_ZERO_HI   = 1;
  localparam int PAT_ONES_LO   = 2;
  localparam int PAT_ONES_HI   = 3;
  localparam int PAT_WALK_BASE = 4;

  function automatic int num_pat(input int width);
    return 2 * width + 4;
  endfunction

  function automatic int idx_w(input int width);
    return $clog2(num_pat(width));
  endfunction

endpackage

// File: rtl/mux32_bist_if.sv
// Drive/sample bundle between the BIST controller and the mux under test.
interface mux32_bist_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data1_o;
  logic [WIDTH-1:0] data2_o;
  logic             select_o;
  logic [WIDTH-1:0] dut_data_i;

  modport master (output data1_o, output data2_o, output select_o, input dut_data_i);
  modport slave  (input data1_o, input data2_o, input select_o, output dut_data_i);
endinterface

// File: rtl/mux32_bist_patgen.sv
// Combinational pattern table: index -> (data1, data2, sel) and golden mux output.
module mux32_bist_patgen
  import mux32_bist_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDX_W = idx_w(WIDTH)
) (
  input  logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] data1,
  output logic [WIDTH-1:0] data2,
  output logic             sel,
  output logic [WIDTH-1:0] expected
);
  logic [IDX_W-1:0] k;
  logic [WIDTH-1:0] one_hot;

  always_comb begin
    // Odd indices select data2, even select data1, for solid and walking patterns alike.
    k       = (idx - IDX_W'(PAT_WALK_BASE)) >> 1;
    one_hot = {{(WIDTH-1){1'b0}}, 1'b1} << k;
    sel     = idx[0];
    data1   = '0;
    data2   = '0;
    case (idx)
      IDX_W'(PAT_ZERO_LO), IDX_W'(PAT_ZERO_HI): begin
        data1 = '0;
        data2 = '1;
      end
      IDX_W'(PAT_ONES_LO), IDX_W'(PAT_ONES_HI): begin
        data1 = '1;
        data2 = '0;
      end
      default: begin
        data1 = one_hot;
        data2 = ~one_hot;
      end
    endcase
    expected = sel ? data2 : data1;
  end
endmodule

// File: rtl/mux32_bist.sv
// BIST controller: walks the pattern table through the mux, compares, and latches the verdict.
module mux32_bist
  import mux32_bist_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int CNT_W = 8,
  localparam int NUM_PAT = num_pat(WIDTH),
  localparam int IDX_W   = idx_w(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  mux32_bist_if.master     mux,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] fail_count_o,
  output logic [IDX_W-1:0] first_fail_idx_o,
  output logic [WIDTH-1:0] first_fail_mask_o
);
  state_e           state;
  logic [IDX_W-1:0] p;
  logic [WIDTH-1:0] pg_d1, pg_d2, pg_exp;
  logic             pg_sel;
  logic [WIDTH-1:0] mask;
  logic             mism;
  logic [CNT_W-1:0] cnt_nxt;

  mux32_bist_patgen #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_patgen (
    .idx      (p),
    .data1    (pg_d1),
    .data2    (pg_d2),
    .sel      (pg_sel),
    .expected (pg_exp)
  );

  // p is stable across APPLY/CHECK, so pg_exp matches what is on the drive registers.
  assign mask    = mux.dut_data_i ^ pg_exp;
  assign mism    = |mask;
  assign cnt_nxt = (mism && fail_count_o != {CNT_W{1'b1}}) ? fail_count_o + 1'b1 : fail_count_o;
  assign busy_o  = (state == ST_APPLY) || (state == ST_CHECK);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state             <= ST_IDLE;
      p                 <= '0;
      mux.data1_o       <= '0;
      mux.data2_o       <= '0;
      mux.select_o      <= 1'b0;
      done_o            <= 1'b0;
      pass_o            <= 1'b0;
      fail_count_o      <= '0;
      first_fail_idx_o  <= '0;
      first_fail_mask_o <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            fail_count_o      <= '0;
            first_fail_idx_o  <= '0;
            first_fail_mask_o <= '0;
            done_o            <= 1'b0;
            pass_o            <= 1'b0;
            p                 <= '0;
            state             <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          mux.data1_o  <= pg_d1;
          mux.data2_o  <= pg_d2;
          mux.select_o <= pg_sel;
          state        <= ST_CHECK;
        end
        ST_CHECK: begin
          if (mism && fail_count_o == '0) begin
            first_fail_idx_o  <= p;
            first_fail_mask_o <= mask;
          end
          fail_count_o <= cnt_nxt;
          if (p == IDX_W'(NUM_PAT - 1)) begin
            done_o       <= 1'b1;
            pass_o       <= (cnt_nxt == '0);
            mux.data1_o  <= '0;
            mux.data2_o  <= '0;
            mux.select_o <= 1'b0;
            state        <= ST_DONE;
          end else begin
            p     <= p + 1'b1;
            state <= ST_APPLY;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mux32_bist.sv
// Randomised fault-injection bench for mux32_bist against a pattern-level reference model.
module tb_mux32_bist;
  import mux32_bist_pkg::*;

  localparam int W  = 32;
  localparam int NP = 2 * W + 4;
  localparam int IW = $clog2(NP);

  typedef struct {
    int             cnt;
    int             idx;
    logic [W-1:0]   mask;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  // fault config: 0 none, 1 stuck-1, 2 stuck-0, 3 all high, 4 flip mask on one walking pattern
  int           f_mode = 0;
  int           f_bit  = 0;
  logic [W-1:0] f_flip = '0;
  logic         f_sel  = 1'b0;

  int checks = 0;
  int failures = 0;
  int busy_cnt = 0;

  mux32_bist_if #(.WIDTH(W)) mif ();
  mux32_bist_if #(.WIDTH(W)) mif4 ();

  logic          busy, done, pass, busy4, done4, pass4;
  logic [7:0]    cnt;
  logic [3:0]    cnt4;
  logic [IW-1:0] fidx, fidx4;
  logic [W-1:0]  fmask, fmask4;

  mux32_bist #(.WIDTH(W), .CNT_W(8)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mux(mif.master),
    .busy_o(busy), .done_o(done), .pass_o(pass), .fail_count_o(cnt),
    .first_fail_idx_o(fidx), .first_fail_mask_o(fmask)
  );

  mux32_bist #(.WIDTH(W), .CNT_W(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mux(mif4.master),
    .busy_o(busy4), .done_o(done4), .pass_o(pass4), .fail_count_o(cnt4),
    .first_fail_idx_o(fidx4), .first_fail_mask_o(fmask4)
  );

  function automatic logic [W-1:0] mux_model(input logic [W-1:0] d1, input logic [W-1:0] d2,
      input logic s, input int mode, input int b, input logic [W-1:0] flip, input logic fs);
    logic [W-1:0] y;
    logic [W-1:0] one;
    y   = s ? d2 : d1;
    one = W'(1) << b;
    case (mode)
      1: y[b] = 1'b1;
      2: y[b] = 1'b0;
      3: y = '1;
      4: if (s == fs && d1 == one) y = y ^ flip;
      default: ;
    endcase
    return y;
  endfunction

  assign mif.dut_data_i  = mux_model(mif.data1_o, mif.data2_o, mif.select_o, f_mode, f_bit, f_flip, f_sel);
  assign mif4.dut_data_i = mux_model(mif4.data1_o, mif4.data2_o, mif4.select_o, f_mode, f_bit, f_flip, f_sel);

  // {sel, data1, data2} for pattern p
  function automatic logic [2*W:0] pattern(input int p);
    logic [W-1:0] a;
    logic s;
    if (p < 4) a = (p >= 2) ? '1 : '0;
    else       a = W'(1) << ((p - 4) / 2);
    s = (p % 2) == 1;
    return {s, a, ~a};
  endfunction

  function automatic res_t model_run(input int mode, input int b, input logic [W-1:0] flip, input logic fs);
    res_t r;
    logic [2*W:0] pt;
    logic [W-1:0] e, m;
    r.cnt = 0; r.idx = 0; r.mask = '0;
    for (int p = 0; p < NP; p++) begin
      pt = pattern(p);
      e  = pt[2*W] ? pt[W-1:0] : pt[2*W-1:W];
      m  = mux_model(pt[2*W-1:W], pt[W-1:0], pt[2*W], mode, b, flip, fs) ^ e;
      if (m != '0) begin
        if (r.cnt == 0) begin r.idx = p; r.mask = m; end
        r.cnt++;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // run-level model: cycle n since the start edge, busy for n=1..2*NP
  int   m_n = 0;
  bit   m_busy = 0, m_done = 0;
  res_t m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_done <= 0; m_n <= 0;
    end else if (m_busy) begin
      if (m_n == 2 * NP) begin m_busy <= 0; m_done <= 1; end
      m_n <= m_n + 1;
    end else if (start) begin
      m_busy <= 1; m_done <= 0; m_n <= 1;
      m_res  <= model_run(f_mode, f_bit, f_flip, f_sel);
    end
  end

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (rst_n) begin
      logic [2*W:0] pt;
      chk("busy", busy, m_busy);
      chk("busy4", busy4, m_busy);
      chk("done", done, m_done);
      chk("done4", done4, m_done);
      if (m_busy && (m_n % 2) == 0) begin
        pt = pattern((m_n - 2) / 2);
        chk("drv_d1", mif.data1_o, pt[2*W-1:W]);
        chk("drv_d2", mif.data2_o, pt[W-1:0]);
        chk("drv_sel", mif.select_o, pt[2*W]);
      end
      if (m_busy) chk("pass_running", pass, 0);
      if (m_done) begin
        chk("pass", pass, m_res.cnt == 0);
        chk("count", cnt, (m_res.cnt > 255) ? 255 : m_res.cnt);
        chk("count4", cnt4, (m_res.cnt > 15) ? 15 : m_res.cnt);
        chk("first_idx", fidx, m_res.idx);
        chk("first_mask", fmask, m_res.mask);
        chk("first_idx4", fidx4, m_res.idx);
        chk("drv_idle", {mif.select_o, mif.data1_o, mif.data2_o}, 0);
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(done && !busy)) begin
      @(negedge clk);
      n++;
      if (n > 400) begin
        chk("done_timeout", 0, 1);
        return;
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int mode, input int b, input logic [W-1:0] flip, input logic fs);
    f_mode = mode; f_bit = b; f_flip = flip; f_sel = fs;
    busy_cnt = 0;
    pulse_start();
    wait_done();
    chk("busy_len", busy_cnt, 2 * NP);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_cnt"}, cnt, 0);
    chk({tag, "_idx"}, fidx, 0);
    chk({tag, "_mask"}, fmask, 0);
    chk({tag, "_drv"}, {mif.select_o, mif.data1_o, mif.data2_o}, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    #1 rst_n = 1'b1;

    run(0, 0, '0, 1'b0);
    chk("ff_pass", pass, 1);
    chk("ff_cnt", cnt, 0);
    chk("ff_idx", fidx, 0);
    chk("ff_mask", fmask, 0);

    run(1, 5, '0, 1'b0);
    chk("sa1b5_cnt", cnt, 34);
    chk("sa1b5_pass", pass, 0);
    chk("sa1b5_idx", fidx, 0);
    chk("sa1b5_mask", fmask, 32'h0000_0020);

    run(2, 0, '0, 1'b0);
    chk("sa0b0_cnt", cnt, 34);
    chk("sa0b0_idx", fidx, 1);
    chk("sa0b0_mask", fmask, 32'h0000_0001);

    run(3, 0, '0, 1'b0);
    chk("hi_cnt", cnt, 66);
    chk("hi_idx", fidx, 0);
    chk("hi_mask", fmask, 32'hFFFF_FFFF);
    chk("hi_cnt4", cnt4, 15);

    // restart from DONE clears results; a start mid-run is ignored
    f_mode = 0;
    busy_cnt = 0;
    pulse_start();
    chk("restart_done", done, 0);
    chk("restart_cnt", cnt, 0);
    chk("restart_mask", fmask, 0);
    repeat (8) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    wait_done();
    chk("midstart_busy_len", busy_cnt, 2 * NP);
    chk("midstart_pass", pass, 1);

    // reset in the middle of a failing run
    f_mode = 1; f_bit = 3;
    pulse_start();
    repeat (19) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("midreset");
    @(posedge clk); #2 rst_n = 1'b1;
    run(1, 3, '0, 1'b0);
    chk("post_reset_cnt", cnt, 34);

    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] fl;
      fl = $urandom;
      if (fl == '0) fl = 32'h8000_0001;
      run($urandom_range(0, 4), $urandom_range(0, W - 1), fl, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mux32_bist.md
# mux32_bist

Built-in self-test controller for the 32-bit 2:1 data mux with fault-injection input. It drives `data1`, `data2` and `select` into the mux under test and samples the mux `data_o` back. The mux output is checked against a golden select model. The block reports pass/fail, a saturating failure count, and the first failing pattern with its bit mask. It sits beside each mux instance in the fault-generation harness, so an injected stuck-at or forced fault becomes a visible verdict.

## Interface
Parameters:
- `WIDTH`, 32: data width of the mux under test; supported range 2..126.
- `CNT_W`, 8: width of the failure counter.

Ports:
- `clk_i`, input, 1: clock.
- `rst_ni`, input, 1: reset, asynchronous, active-low.
- `start_i`, input, 1: one-cycle start pulse.
- `data1_o`, output, WIDTH: registered drive to mux `data1_i`.
- `data2_o`, output, WIDTH: registered drive to mux `data2_i`.
- `select_o`, output, 1: registered drive to mux `select_i`.
- `dut_data_i`, input, WIDTH: mux `data_o` sampled back.
- `busy_o`, output, 1: high while a test is running.
- `done_o`, output, 1: high once a test has completed; held until the next start.
- `pass_o`, output, 1: valid when `done_o` is high; 1 means zero mismatches.
- `fail_count_o`, output, CNT_W: number of mismatching patterns, saturating.
- `first_fail_idx_o`, output, IDX_W: index of the first failing pattern; 0 if none failed.
- `first_fail_mask_o`, output, WIDTH: XOR of actual vs expected at the first failing pattern.

## Operation
- Pattern count: NUM_PAT = 2*WIDTH+4, which is 68 for WIDTH=32. IDX_W = clog2(NUM_PAT).
- Patterns given as (data1, data2, sel), for index p:
  - p=0: (0, all-ones, 0)
  - p=1: (0, all-ones, 1)
  - p=2: (all-ones, 0, 0)
  - p=3: (all-ones, 0, 1)
  - p=4+2k: (1<<k, ~(1<<k), 0)
  - p=5+2k: (1<<k, ~(1<<k), 1)
- Expected value: sel ? data2 : data1. Mismatch mask = dut_data_i XOR expected.
- FSM states: IDLE, APPLY, CHECK, DONE.
- IDLE:
  - Outputs are held.
  - On `start_i`: clear `fail_count_o`, `first_fail_*`, `done_o`, `pass_o`; set p=0; go to APPLY.
- APPLY: register the pattern p onto the drive outputs; go to CHECK.
- CHECK: sample `dut_data_i` and compare against expected.
  - On a nonzero mask: if the count is 0, capture p and the mask into `first_fail_*`. Then increment the count, saturating at 2^CNT_W-1.
  - If p = NUM_PAT-1, go to DONE. Otherwise p++ and go to APPLY.
- DONE:
  - Set `done_o`=1 and `pass_o`=(count==0). The drive outputs return to 0.
  - On `start_i`, restart exactly as from IDLE.
- `start_i` in APPLY or CHECK is ignored.
- `busy_o` = state is APPLY or CHECK.
- Reset (asynchronous, any time, including mid-run):
  - State goes to IDLE.
  - All outputs go to 0, including `pass_o`=0 and `done_o`=0.
  - The next start runs the full sequence.

## Timing
- The mux under test is combinational. A pattern is registered in APPLY and sampled at the end of CHECK, giving one full cycle of settle.
- 2 cycles per pattern. `busy_o` rises the cycle after `start_i` and stays high for 2*NUM_PAT cycles (136 for WIDTH=32).
- `done_o` and final results are valid on the first DONE cycle and are stable thereafter.
- The results outputs are registered; there is no combinational path from `dut_data_i` to any output.

## Structure
- Package `mux32_bist_pkg`:
  - state enum.
  - `num_pat(width)` and `idx_w(width)` functions.
  - Solid-pattern index constants 0..3.
- Sub-module `mux32_bist_patgen`: combinational map from index p to (data1, data2, sel, expected), parameterised by WIDTH.
- The top level holds the FSM, the index counter, the compare logic and the result registers.

## Test plan
All scenarios use WIDTH=32 (NUM_PAT=68) unless stated otherwise.
- Fault-free mux model, `start_i` pulse: `busy_o` high for 136 cycles, then `done_o`=1, `pass_o`=1, count=0, idx=0, mask=0.
- Bit 5 stuck-at-1: count=34, `pass_o`=0, `first_fail_idx_o`=0, `first_fail_mask_o`=0x00000020.
- Bit 0 stuck-at-0: count=34, `first_fail_idx_o`=1, `first_fail_mask_o`=0x00000001.
- Fault input f=1 forcing all outputs high:
  - count=66 (only p=1 and p=2 pass), idx=0, mask=0xFFFFFFFF.
  - Rerun with CNT_W=4: count saturates at 15.
- `rst_ni` low for 1 cycle at cycle 20 of a run: all outputs read 0 and the FSM returns to IDLE. A new start gives a correct full 136-cycle run.
- `start_i` pulsed at cycle 10 of a run: ignored, total busy time still 136 cycles. `start_i` in DONE clears the results and reruns.
